ff_bank_arbiter: RTL
====================

FF_BANK_ARBITER -- requirements
Module: ff_bank_arbiter

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and act as the single clock; all state updates on its posedge.
REQ-002 The port rst SHALL be an input, 1 bit wide, asynchronous and active-high, and clear all state immediately when asserted.
REQ-003 The port req_valid SHALL be an input, 4 bits wide; bit i asserts a pending request from requester i.
REQ-004 The port req_op SHALL be an input, 8 bits wide; bits [2i+1:2i] carry requester i's opcode: 00 hold, 01 toggle (T-mode, q^=mask), 10 load (D-mode, q=data), 11 clear.
REQ-005 The port req_data SHALL be an input, 32 bits wide; bits [8i+7:8i] carry requester i's mask (toggle) or data (load).
REQ-006 The port req_ready SHALL be an output, 4 bits wide, at most one-hot; bit i set accepts requester i's op in that cycle.
REQ-007 The port q SHALL be an output, 8 bits wide, holding the shared flip-flop bank state (registered).
REQ-008 The port done SHALL be an output, 1 bit wide, pulsing for one cycle when an op is applied to q.
REQ-009 The port gnt_id SHALL be an output, 2 bits wide, giving the index of the requester whose op is being applied; valid when done=1.
REQ-010 The port tog_cnt SHALL be an output, 8 bits wide, carrying the toggle-operation counter (see Configuration).

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and EXEC.
REQ-012 In IDLE with req_valid!=0, the block SHALL assert req_ready for one requester chosen round-robin, latch its opcode/data and index, and transition to EXEC.
REQ-013 The round-robin search SHALL begin at (last_grant+1) mod 4 and wrap 3->0; last_grant updates on every accept.
REQ-014 In IDLE with req_valid==0, the block SHALL keep req_ready=0 and remain in IDLE.
REQ-015 In EXEC the block SHALL apply the latched op at the clock edge: hold q=q; toggle q=q^mask; load q=data; clear q=8'h00.
REQ-016 done SHALL be 1 and gnt_id SHALL equal the latched index in the cycle after the EXEC edge, i.e. done is registered and coincides with the updated q.
REQ-017 EXEC SHALL always return to IDLE after one cycle; req_ready SHALL be 0 throughout EXEC, so throughput is at most one op per 2 cycles.
REQ-018 Request-to-q latency SHALL be 2 edges: accept edge, then apply edge.
REQ-019 A requester SHALL hold valid/op/data stable until its req_ready; dropping req_valid before grant withdraws the request with no effect.
REQ-020 A toggle with mask=0 or a hold op SHALL still produce a done pulse and consume the requester's turn.
REQ-021 Simultaneous valid from all four requesters SHALL be served in rotation with no requester starved; worst-case wait is 3 ops (6 cycles).

Reset
REQ-022 While rst=1: q=8'h00, state=IDLE, req_ready=0, done=0, gnt_id=0, tog_cnt=0, latched op cleared, last_grant=3 (so requester 0 wins first).
REQ-023 rst asserted during EXEC SHALL abort the pending op; q SHALL stay 0 after release.

Configuration
REQ-024 With FF_BANK_TOGGLE_CNT_EN defined, tog_cnt SHALL increment by 1 on each applied toggle op (including mask=0) and saturate at 8'hFF.
REQ-025 Without FF_BANK_TOGGLE_CNT_EN, tog_cnt SHALL be tied to 8'h00, with no counter logic present; all other behaviour is identical.

Verification
REQ-026 After reset, requester 0 loads 8'hA5 -> req_ready=4'b0001 at the accept edge; q=8'hA5, done=1, gnt_id=0 one edge later.
REQ-027 Starting from q=8'hA5, requester 2 toggles 8'hFF -> q=8'h5A; with the macro, tog_cnt=1; without it, tog_cnt=0.
REQ-028 With all four valid held (ops: load 01, toggle 03, toggle 0C, clear) -> grants go 0,1,2,3 and q goes 01,02,0E,00, with a done pulse every 2 cycles.
REQ-029 rst pulsed in EXEC of a load 8'hFF -> q=00, done never asserts; the next grant goes to requester 0.
REQ-030 With the macro defined, 300 toggle ops are applied -> tog_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter
//   Four requesters share one 8-bit flip-flop bank. A round-robin arbiter
//   accepts one request at a time. The accepted op (hold/toggle/load/clear)
//   is applied on the following edge. A registered done pulse and gnt_id
//   change on the same edge as q.
//
// Ports
//   clk        single clock, posedge
//   rst        asynchronous active-high reset
//   req_valid  [3:0]  per-requester request pending
//   req_op     [7:0]  requester i opcode in [2i+1:2i]
//                     00 hold, 01 toggle, 10 load, 11 clear
//   req_data   [31:0] requester i mask/data in [8i+7:8i]
//   req_ready  [3:0]  at most one-hot; accepts requester i this cycle
//   q          [7:0]  flip-flop bank state (registered)
//   done              one-cycle pulse when an op has been applied to q
//   gnt_id     [1:0]  requester whose op was applied (valid with done)
//   tog_cnt    [7:0]  saturating count of applied toggle ops
//
// Optional feature
//   FF_BANK_TOGGLE_CNT_EN  when defined, tog_cnt counts applied toggles.
//                          When not defined, tog_cnt is tied to 0.
//
// Handshake
//   A transfer happens on a rising edge where req_valid[i] && req_ready[i].
//   A requester holds valid/op/data stable until it sees ready. Dropping
//   valid before ready withdraws the request, and the withdrawal has no
//   effect. req_ready depends combinationally on req_valid. It can only be
//   high while the FSM is in IDLE and rst is low.

module ff_bank_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  q,
  output logic        done,
  output logic [1:0]  gnt_id,
  output logic [7:0]  tog_cnt
);

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state, state_nxt;
  logic [1:0] last_grant;
  logic [1:0] lat_idx;
  logic [1:0] lat_op;
  logic [7:0] lat_data;
  logic [1:0] pick_idx;
  logic       pick_vld;
  logic       accept;
  logic [1:0] cand;

  // Round-robin pick. The loop runs from the farthest candidate down to
  // the nearest one, so the last write wins. The winner is therefore the
  // first valid requester after last_grant, counting forward with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_grant;
    cand     = last_grant;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next state and handshake. rst gates ready so nothing is offered in reset.
  always_comb begin
    state_nxt = state;
    req_ready = 4'b0000;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && !rst) begin
          accept              = 1'b1;
          req_ready[pick_idx] = 1'b1;
          state_nxt           = EXEC;
        end
      end
      EXEC: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      lat_idx    <= 2'd0;
      lat_op     <= OP_HOLD;
      lat_data   <= 8'h00;
      q          <= 8'h00;
      done       <= 1'b0;
      gnt_id     <= 2'd0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        lat_idx    <= pick_idx;
        lat_op     <= req_op[{pick_idx, 1'b0} +: 2];
        lat_data   <= req_data[{pick_idx, 3'b000} +: 8];
        last_grant <= pick_idx;
      end
      if (state == EXEC) begin
        case (lat_op)
          OP_HOLD:   q <= q;
          OP_TOGGLE: q <= q ^ lat_data;
          OP_LOAD:   q <= lat_data;
          OP_CLEAR:  q <= 8'h00;
          default:   q <= q;
        endcase
        done   <= 1'b1;
        gnt_id <= lat_idx;
      end
    end
  end

`ifdef FF_BANK_TOGGLE_CNT_EN
  // Every applied toggle counts, including one with mask 0. The count
  // stops at 8'hFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_cnt <= 8'h00;
    end else if (state == EXEC && lat_op == OP_TOGGLE && tog_cnt != 8'hFF) begin
      tog_cnt <= tog_cnt + 8'd1;
    end
  end
`else
  assign tog_cnt = 8'h00;
`endif

endmodule
